// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: data-first priority with an instruction
// starvation override, plus a one-cycle read response tracker.
module mem_port_arbiter #(
   parameter int AW         = 30,
   parameter int DW         = 32,
   parameter int STARVE_LIM = 3
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          IREQ,
   input  logic [AW-1:0] IADDR,
   output logic          IGNT,
   output logic          IRVALID,
   output logic [DW-1:0] IRDATA,
   input  logic          DREQ,
   input  logic          DRW,
   input  logic [AW-1:0] DADDR,
   input  logic [DW-1:0] DWDATA,
   output logic          DGNT,
   output logic          DRVALID,
   output logic [DW-1:0] DRDATA,
   output logic          MREQ,
   output logic          MWE,
   output logic [AW-1:0] MADDR,
   output logic [DW-1:0] MWDATA,
   input  logic [DW-1:0] MRDATA,
   output logic          ISTALL
);

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      IRESP = 2'd1,
      DRESP = 2'd2
   } resp_e;

   localparam logic [2:0] LIM  = 3'(STARVE_LIM);
   localparam logic [2:0] SMAX = 3'd7;

   resp_e      state;
   resp_e      state_nxt;
   logic [2:0] scnt;
   logic [2:0] scnt_nxt;
   logic       starve;
   logic       i_win;
   logic       igrant;
   logic       dgrant;

   assign starve = (scnt >= LIM);
   assign i_win  = IREQ && (starve || !DREQ);

   // Grants are forced low in reset so nothing reaches the memory.
   always_comb begin
      igrant = 1'b0;
      dgrant = 1'b0;
      if (RSTN) begin
         unique case (1'b1)
            i_win:            igrant = 1'b1;
            (DREQ && !i_win): dgrant = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      scnt_nxt = scnt;
      if (igrant) begin
         scnt_nxt = 3'd0;
      end else if (IREQ && (scnt != SMAX)) begin
         scnt_nxt = scnt + 3'd1;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         scnt <= 3'd0;
      end else begin
         scnt <= scnt_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= NONE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = NONE;
      unique case (1'b1)
         igrant:            state_nxt = IRESP;
         (dgrant && !DRW):  state_nxt = DRESP;
         default: ;
      endcase
   end

   always_comb begin
      IRVALID = 1'b0;
      IRDATA  = '0;
      DRVALID = 1'b0;
      DRDATA  = '0;
      unique case (state)
         IRESP: begin
            IRVALID = 1'b1;
            IRDATA  = MRDATA;
         end
         DRESP: begin
            DRVALID = 1'b1;
            DRDATA  = MRDATA;
         end
         default: ;
      endcase
   end

   always_comb begin
      MADDR = '0;
      unique case (1'b1)
         igrant: MADDR = IADDR;
         dgrant: MADDR = DADDR;
         default: ;
      endcase
   end

   assign IGNT   = igrant;
   assign DGNT   = dgrant;
   assign MREQ   = igrant | dgrant;
   assign MWE    = dgrant & DRW;
   assign MWDATA = MWE ? DWDATA : '0;
   assign ISTALL = RSTN & IREQ & ~igrant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with a response
// scoreboard fed by a small memory model.
module tb_mem_port_arbiter;

   localparam int AW  = 30;
   localparam int DW  = 32;
   localparam int LIM = 3;

   typedef struct {
      bit          side;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic          CLK;
   logic          RSTN;
   logic          IREQ;
   logic [AW-1:0] IADDR;
   logic          IGNT;
   logic          IRVALID;
   logic [DW-1:0] IRDATA;
   logic          DREQ;
   logic          DRW;
   logic [AW-1:0] DADDR;
   logic [DW-1:0] DWDATA;
   logic          DGNT;
   logic          DRVALID;
   logic [DW-1:0] DRDATA;
   logic          MREQ;
   logic          MWE;
   logic [AW-1:0] MADDR;
   logic [DW-1:0] MWDATA;
   logic [DW-1:0] MRDATA = '0;
   logic          ISTALL;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   mon_en = 0;
   exp_t q[$];
   logic [31:0] mem[int];

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT),
      .IRVALID(IRVALID), .IRDATA(IRDATA),
      .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
      .DGNT(DGNT), .DRVALID(DRVALID), .DRDATA(DRDATA),
      .MREQ(MREQ), .MWE(MWE), .MADDR(MADDR), .MWDATA(MWDATA),
      .MRDATA(MRDATA), .ISTALL(ISTALL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [31:0] rdval(input int a);
      if (mem.exists(a)) return mem[a];
      if (a == 32'h10) return 32'hDEADBEEF;
      return 32'hC0DE0000 ^ a;
   endfunction

   // Memory model: write on the strobe edge, read data one cycle later.
   always @(posedge CLK) begin
      if (MREQ && MWE) mem[int'(MADDR)] = MWDATA;
      if (MREQ && !MWE) MRDATA <= rdval(int'(MADDR));
   end

   // Scoreboard: every negedge both response ports are checked.
   always @(negedge CLK) begin
      exp_t        e;
      bit          ei;
      bit          ed;
      logic [31:0] di;
      logic [31:0] dd;
      if (mon_en) begin
         ei = 0; ed = 0; di = '0; dd = '0;
         while (q.size() > 0 && q[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL stale_resp due=%0d now=%0d", q[0].due, cyc);
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.side) begin ei = 1; di = e.data; end
            else begin ed = 1; dd = e.data; end
         end
         checks += 4;
         if (IRVALID !== ei) begin
            errors++;
            $display("FAIL irvalid c%0d got=%b exp=%b", cyc, IRVALID, ei);
         end
         if (IRDATA !== di) begin
            errors++;
            $display("FAIL irdata c%0d got=%h exp=%h", cyc, IRDATA, di);
         end
         if (DRVALID !== ed) begin
            errors++;
            $display("FAIL drvalid c%0d got=%b exp=%b", cyc, DRVALID, ed);
         end
         if (DRDATA !== dd) begin
            errors++;
            $display("FAIL drdata c%0d got=%h exp=%h", cyc, DRDATA, dd);
         end
      end
   end

   task automatic push(input bit side, input logic [31:0] d);
      exp_t e;
      e.side = side; e.data = d; e.due = cyc + 1;
      q.push_back(e);
   endtask

   task automatic idle();
      IREQ = 0; IADDR = '0; DREQ = 0; DRW = 0; DADDR = '0; DWDATA = '0;
   endtask

   task automatic test_reset();
      RSTN = 0; IREQ = 1; DREQ = 1; DADDR = 30'h7; IADDR = 30'h9;
      repeat (2) @(negedge CLK);
      #1;
      checks++;
      if ({IGNT, DGNT, MREQ, MWE, ISTALL, IRVALID, DRVALID} !== 7'b0 ||
          MADDR !== '0 || MWDATA !== '0 || IRDATA !== '0 || DRDATA !== '0) begin
         errors++;
         $display("FAIL reset_outs got=%b%b%b%b%b%b%b exp=0",
                  IGNT, DGNT, MREQ, MWE, ISTALL, IRVALID, DRVALID);
      end
      checks++;
      if (dut.scnt !== 3'd0) begin
         errors++;
         $display("FAIL reset_scnt got=%0d exp=0", dut.scnt);
      end
      @(negedge CLK);
      idle();
      IREQ = 1; IADDR = 30'h3;
      RSTN = 1;
      #1;
      checks++;
      if (IGNT !== 1'b1 || MADDR !== 30'h3) begin
         errors++;
         $display("FAIL first_grant got=%b/%h exp=1/3", IGNT, MADDR);
      end
      @(negedge CLK);
      idle();
      @(negedge CLK);
      q.delete();
      mon_en = 1;
   endtask

   task automatic test_fetch();
      @(negedge CLK);
      IREQ = 1; IADDR = 30'h10;
      #1;
      checks++;
      if (IGNT !== 1 || DGNT !== 0 || MREQ !== 1 || MWE !== 0 ||
          MADDR !== 30'h10 || ISTALL !== 0) begin
         errors++;
         $display("FAIL fetch_grant got=%b%b%b%b %h exp=1010 10",
                  IGNT, DGNT, MREQ, MWE, MADDR);
      end
      push(1, 32'hDEADBEEF);
      @(negedge CLK);
      idle();
      @(negedge CLK);
   endtask

   task automatic test_simul();
      @(negedge CLK);
      IREQ = 1; IADDR = 30'h30; DREQ = 1; DRW = 0; DADDR = 30'h20;
      #1;
      checks++;
      if (DGNT !== 1 || IGNT !== 0 || ISTALL !== 1 || MADDR !== 30'h20) begin
         errors++;
         $display("FAIL simul_c0 got=%b%b%b %h exp=101 20",
                  DGNT, IGNT, ISTALL, MADDR);
      end
      push(0, rdval(32'h20));
      @(negedge CLK);
      DREQ = 0;
      #1;
      checks++;
      if (IGNT !== 1 || DGNT !== 0 || MADDR !== 30'h30) begin
         errors++;
         $display("FAIL simul_c1 got=%b%b %h exp=10 30", IGNT, DGNT, MADDR);
      end
      push(1, rdval(32'h30));
      @(negedge CLK);
      idle();
      @(negedge CLK);
   endtask

   task automatic test_starve();
      logic [5:0] ipat;
      int         se[6];
      ipat = 6'b001000;
      se = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         IREQ = 1; IADDR = 30'h40; DREQ = 1; DRW = 0; DADDR = 30'h41;
         #1;
         checks++;
         if (dut.scnt !== 3'(se[i])) begin
            errors++;
            $display("FAIL starve_scnt c%0d got=%0d exp=%0d", i, dut.scnt, se[i]);
         end
         checks++;
         if (IGNT !== ipat[i] || DGNT !== !ipat[i] || ISTALL !== !ipat[i]) begin
            errors++;
            $display("FAIL starve_gnt c%0d got=%b%b%b exp=%b%b%b", i,
                     IGNT, DGNT, ISTALL, ipat[i], !ipat[i], !ipat[i]);
         end
         push(ipat[i], rdval(ipat[i] ? 32'h40 : 32'h41));
      end
      @(negedge CLK);
      idle();
      @(negedge CLK);
   endtask

   task automatic test_write();
      @(negedge CLK);
      DREQ = 1; DRW = 1; DADDR = 30'h5; DWDATA = 32'h1234;
      #1;
      checks++;
      if (MREQ !== 1 || MWE !== 1 || DGNT !== 1 ||
          MADDR !== 30'h5 || MWDATA !== 32'h1234) begin
         errors++;
         $display("FAIL write got=%b%b%b %h %h exp=111 5 1234",
                  MREQ, MWE, DGNT, MADDR, MWDATA);
      end
      @(negedge CLK);
      idle();
      #1;
      checks++;
      if (MREQ !== 0 || MWE !== 0 || MWDATA !== '0) begin
         errors++;
         $display("FAIL write_idle got=%b%b %h exp=00 0", MREQ, MWE, MWDATA);
      end
      @(negedge CLK);
      DREQ = 1; DRW = 0; DADDR = 30'h5;
      #1;
      push(0, 32'h1234);
      @(negedge CLK);
      idle();
      @(negedge CLK);
   endtask

   task automatic test_alternate();
      bit          is_i;
      logic [29:0] a;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         idle();
         is_i = (i % 2 == 0);
         a = 30'(is_i ? 8'h50 + i : 8'h60 + i);
         if (is_i) begin IREQ = 1; IADDR = a; end
         else begin DREQ = 1; DRW = 0; DADDR = a; end
         #1;
         checks++;
         if (IGNT !== is_i || DGNT !== !is_i || MADDR !== a) begin
            errors++;
            $display("FAIL alt c%0d got=%b%b %h exp=%b%b %h", i,
                     IGNT, DGNT, MADDR, is_i, !is_i, a);
         end
         push(is_i, rdval(int'(a)));
      end
      @(negedge CLK);
      idle();
      @(negedge CLK);
   endtask

   task automatic test_reset_pending();
      mon_en = 0;
      q.delete();
      @(negedge CLK);
      IREQ = 1; IADDR = 30'h10;
      #1;
      checks++;
      if (IGNT !== 1) begin
         errors++;
         $display("FAIL rp_grant got=%b exp=1", IGNT);
      end
      #1;
      RSTN = 0;
      #1;
      checks++;
      if ({IGNT, MREQ, ISTALL, IRVALID} !== 4'b0 || MADDR !== '0) begin
         errors++;
         $display("FAIL rp_low got=%b%b%b%b %h exp=0000 0",
                  IGNT, MREQ, ISTALL, IRVALID, MADDR);
      end
      @(negedge CLK);
      checks++;
      if (IRVALID !== 0 || IRDATA !== '0) begin
         errors++;
         $display("FAIL rp_noresp got=%b %h exp=0 0", IRVALID, IRDATA);
      end
      RSTN = 1;
      #1;
      checks++;
      if (IGNT !== 1) begin
         errors++;
         $display("FAIL rp_regrant got=%b exp=1", IGNT);
      end
      @(negedge CLK);
      idle();
      checks++;
      if (IRVALID !== 1 || IRDATA !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rp_resp got=%b %h exp=1 deadbeef", IRVALID, IRDATA);
      end
      #1;
      RSTN = 0;
      #1;
      checks++;
      if (IRVALID !== 0 || IRDATA !== '0) begin
         errors++;
         $display("FAIL rp_drop got=%b %h exp=0 0", IRVALID, IRDATA);
      end
      @(negedge CLK);
      RSTN = 1;
      @(negedge CLK);
      checks++;
      if (IRVALID !== 0 || DRVALID !== 0) begin
         errors++;
         $display("FAIL rp_nopulse got=%b%b exp=00", IRVALID, DRVALID);
      end
      q.delete();
      mon_en = 1;
   endtask

   initial begin
      idle();
      RSTN = 0;
      test_reset();
      test_fetch();
      test_simul();
      test_starve();
      test_write();
      test_alternate();
      test_reset_pending();
      repeat (3) @(negedge CLK);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL leftover_resp got=%0d exp=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
